// File: rtl/rand_stream_checker_pkg.sv
// Shared xorshift32 constants, forward/inverse step functions and checker FSM states.
// The generator side uses the same shift constants.
package rand_stream_checker_pkg;

    localparam int unsigned XS_A = 13;
    localparam int unsigned XS_B = 17;
    localparam int unsigned XS_C = 5;

    typedef enum logic {
        IDLE,
        COLLECT
    } state_e;

    function automatic logic [31:0] xs_fwd(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << XS_A);
        y = y ^ (y >> XS_B);
        y = y ^ (y << XS_C);
        return y;
    endfunction

    // Each inverse undoes one xor-shift by folding in every multiple of the shift.
    function automatic logic [31:0] xs_inv_c(input logic [31:0] y);
        logic [31:0] r;
        r = y;
        for (int unsigned s = XS_C; s < 32; s += XS_C) r = r ^ (y << s);
        return r;
    endfunction

    function automatic logic [31:0] xs_inv_b(input logic [31:0] y);
        logic [31:0] r;
        r = y;
        for (int unsigned s = XS_B; s < 32; s += XS_B) r = r ^ (y >> s);
        return r;
    endfunction

    function automatic logic [31:0] xs_inv_a(input logic [31:0] y);
        logic [31:0] r;
        r = y;
        for (int unsigned s = XS_A; s < 32; s += XS_A) r = r ^ (y << s);
        return r;
    endfunction

endpackage

// File: rtl/rand_stream_checker_inv_pipe.sv
// Three-stage registered xorshift32 inverse: recovers the seed from the first stream word.
module xorshift_inv_pipe
    import rand_stream_checker_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        out_valid,
    output logic [31:0] seed
);

    logic [31:0] s1_q, s2_q, s3_q;
    logic [2:0]  v_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
            v_q  <= '0;
        end else begin
            v_q <= {v_q[1:0], in_valid};
            if (in_valid) s1_q <= xs_inv_c(in_data);
            if (v_q[0])   s2_q <= xs_inv_b(s1_q);
            if (v_q[1])   s3_q <= xs_inv_a(s2_q);
        end
    end

    assign out_valid = v_q[2];
    assign seed      = s3_q;

endmodule

// File: rtl/rand_stream_checker.sv
// Frame checker for the xorshift32 stream: echoes the recovered seed and counts
// broken chain links once per FRAME_LEN-word frame.
module rand_stream_checker
    import rand_stream_checker_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [31:0]      rand_num,
    output logic             out_valid,
    output logic [31:0]      seed_out,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             frame_ok
);

    localparam int unsigned CW = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [31:0]      prev_q, prev_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic             ov_q, ov_d;
    logic             mis;
    logic             pipe_valid_unused;
    logic [31:0]      pipe_seed;

    xorshift_inv_pipe u_inv (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid && (state_q == IDLE)),
        .in_data   (rand_num),
        .out_valid (pipe_valid_unused),
        .seed      (pipe_seed)
    );

    assign mis = (rand_num != xs_fwd(prev_q));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prev_d  = prev_q;
        acc_d   = acc_q;
        ov_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    prev_d  = rand_num;
                    cnt_d   = CW'(1);
                    acc_d   = '0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    prev_d = rand_num;
                    cnt_d  = cnt_q + CW'(1);
                    if (mis && (acc_q != '1)) acc_d = acc_q + CNT_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        ov_d    = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prev_q  <= '0;
            acc_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            acc_q   <= acc_d;
            ov_q    <= ov_d;
        end
    end

    // The accumulator and seed register are only overwritten after the pulse cycle.
    assign out_valid    = ov_q;
    assign seed_out     = ov_q ? pipe_seed : '0;
    assign mismatch_cnt = ov_q ? acc_q : '0;
    assign frame_ok     = ov_q && (acc_q == '0);

endmodule

// File: tb/tb_rand_stream_checker.sv
// Scoreboard bench for rand_stream_checker: frames are generated by a local xorshift
// model, expected results queued at the last word and compared on each out_valid pulse.
module tb_rand_stream_checker;

    localparam int unsigned FLEN = 256;
    localparam int unsigned CW   = 8;

    typedef struct {
        logic [31:0]   seed;
        logic [CW-1:0] cnt;
        logic          ok;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [31:0]   rand_num = '0;
    logic          out_valid;
    logic [31:0]   seed_out;
    logic [CW-1:0] mismatch_cnt;
    logic          frame_ok;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];

    rand_stream_checker #(
        .FRAME_LEN (FLEN),
        .CNT_W     (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .rand_num     (rand_num),
        .out_valid    (out_valid),
        .seed_out     (seed_out),
        .mismatch_cnt (mismatch_cnt),
        .frame_ok     (frame_ok)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] tb_fwd(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        return y ^ (y << 5);
    endfunction

    // Monitor: gated outputs must be zero between pulses; pulses pop the scoreboard.
    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 64'(out_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("seed_out", 64'(seed_out), 64'(e.seed));
                check("mismatch_cnt", 64'(mismatch_cnt), 64'(e.cnt));
                check("frame_ok", 64'(frame_ok), 64'(e.ok));
                check("pulse_cycle", 64'(cyc), 64'(e.cyc));
            end
        end else if (rst_n) begin
            check("idle_gating", {23'd0, seed_out, mismatch_cnt, frame_ok}, 64'd0);
        end
    end

    task automatic send_word(input logic [31:0] w, input int gap, input bit last, input exp_t e);
        exp_t ee;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        rand_num = w;
        if (last) begin
            ee     = e;
            ee.cyc = cyc + 1;
            sb.push_back(ee);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] seed, input int flip_idx, input int max_gap,
                              input int n_words);
        logic [31:0] x, w, prev;
        int          mis;
        exp_t        e;
        x    = tb_fwd(seed);
        prev = '0;
        mis  = 0;
        for (int i = 0; i < n_words; i++) begin
            w = (i == flip_idx) ? (x ^ 32'd1) : x;
            if (i > 0 && w != tb_fwd(prev)) mis++;
            prev   = w;
            e.seed = seed;
            e.cnt  = (mis > 255) ? 8'hFF : CW'(mis);
            e.ok   = (mis == 0);
            e.cyc  = 0;
            send_word(w, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0,
                      (i == int'(FLEN) - 1), e);
            x = tb_fwd(x);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outputs", {23'd0, seed_out, mismatch_cnt, frame_ok}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send_frame(32'h0000_0001, -1, 0, FLEN);          // T1
        repeat (3) @(posedge clk);
        #1;
        send_frame(32'h0000_0000, -1, 0, FLEN);          // T2
        repeat (3) @(posedge clk);
        #1;
        send_frame(32'hDEAD_BEEF, 100, 0, FLEN);         // T3
        repeat (3) @(posedge clk);
        #1;
        send_frame(32'h0000_0001, -1, 5, FLEN);          // T4
        repeat (3) @(posedge clk);
        #1;
        send_frame(32'h0000_0001, -1, 0, FLEN);          // T5 back-to-back
        send_frame(32'h0000_0002, -1, 0, FLEN);
        repeat (3) @(posedge clk);
        #1;
        send_frame(32'h0000_0005, -1, 0, 51);            // T6 partial, then reset
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(32'h0000_0003, -1, 0, FLEN);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
